// File: rtl/fifo_scoreboard_if.sv
// Observation bundle between a synchronous FIFO and its scoreboard.
// master drives the FIFO-side signals; slave only monitors them.
interface fifo_scoreboard_if #(
  parameter int DATA_W = 32
);
  logic              write_en;
  logic              read_en;
  logic              full;
  logic              empty;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data;

  modport master (
    output write_en, read_en, full, empty,
    output write_data, read_data
  );

  modport slave (
    input write_en, read_en, full, empty,
    input write_data, read_data
  );
endinterface

// File: rtl/fifo_scoreboard.sv
// In-order shadow-queue checker for synchronous FIFOs.
// Define FIFO_SB_ERR_LOG_EN to add the first-data-error capture ports.
module fifo_scoreboard #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 8,
  parameter  int RD_LAT = 0,
  parameter  int CNT_W  = 16,
  localparam int CW     = $clog2(DEPTH + 1),
  localparam int PW     = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  fifo_scoreboard_if.slave bus,
  output logic [CW-1:0]    model_count,
  output logic [CNT_W-1:0] match_cnt,
  output logic             err_data,
  output logic             err_flag,
  output logic             err_ovf,
  output logic             err_udf,
  output logic             err_any
`ifdef FIFO_SB_ERR_LOG_EN
  ,
  output logic [DATA_W-1:0] log_exp,
  output logic [DATA_W-1:0] log_act,
  output logic [CNT_W-1:0]  log_idx
`endif
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;

  logic wr_acc, rd_acc;
  logic is_empty, is_full;
  logic push, pop, do_cmp;
  logic ovf_hit, udf_hit, flag_bad;
  logic data_bad, data_ok;
  logic cmp_v;
  logic [DATA_W-1:0] exp_d;
  logic [DATA_W-1:0] cmp_exp;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign is_empty = (model_count == '0);
  assign is_full  = (model_count == CW'(DEPTH));

  assign wr_acc = bus.write_en &&
                  (!bus.full || bus.read_en);
  assign rd_acc = bus.read_en &&
                  (!bus.empty || bus.write_en);

  // An empty model with a same-cycle write
  // bypasses the queue entirely.
  assign push   = wr_acc &&
                  (rd_acc ? !is_empty : !is_full);
  assign pop    = rd_acc && !is_empty;
  assign do_cmp = rd_acc && (!is_empty || wr_acc);
  assign exp_d  = is_empty ? bus.write_data
                           : mem[rd_ptr];

  assign ovf_hit  = wr_acc && !rd_acc && is_full;
  assign udf_hit  = rd_acc && !wr_acc && is_empty;
  assign flag_bad = (bus.full  != is_full) ||
                    (bus.empty != is_empty);

  generate
    if (RD_LAT == 0) begin : g_lat0
      assign cmp_v   = do_cmp;
      assign cmp_exp = exp_d;
    end else begin : g_lat1
      logic              pend_q;
      logic [DATA_W-1:0] exp_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          pend_q <= 1'b0;
          exp_q  <= '0;
        end else begin
          pend_q <= do_cmp;
          if (do_cmp) exp_q <= exp_d;
        end
      end
      assign cmp_v   = pend_q;
      assign cmp_exp = exp_q;
    end
  endgenerate

  assign data_bad = cmp_v &&
                    (bus.read_data != cmp_exp);
  assign data_ok  = cmp_v && !data_bad;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.write_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      model_count <= '0;
      match_cnt   <= '0;
      err_data    <= 1'b0;
      err_flag    <= 1'b0;
      err_ovf     <= 1'b0;
      err_udf     <= 1'b0;
    end else begin
      if (push) wr_ptr <= nxt(wr_ptr);
      if (pop)  rd_ptr <= nxt(rd_ptr);
      if (push && !pop)
        model_count <= model_count + 1'b1;
      else if (pop && !push)
        model_count <= model_count - 1'b1;
      if (data_ok && match_cnt != '1)
        match_cnt <= match_cnt + 1'b1;
      err_data <= err_data | data_bad;
      err_flag <= err_flag | flag_bad;
      err_ovf  <= err_ovf  | ovf_hit;
      err_udf  <= err_udf  | udf_hit;
    end
  end

`ifdef FIFO_SB_ERR_LOG_EN
  // Only the first data error is kept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      log_exp <= '0;
      log_act <= '0;
      log_idx <= '0;
    end else if (data_bad && !err_data) begin
      log_exp <= cmp_exp;
      log_act <= bus.read_data;
      log_idx <= match_cnt;
    end
  end
`endif

  assign err_any = err_data | err_flag |
                   err_ovf  | err_udf;

endmodule

// File: tb/tb_fifo_scoreboard.sv
// Bench for fifo_scoreboard: vector table, directed corner sequences,
// and randomized traffic against a queue-based reference.
module tb_fifo_scoreboard;

  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic we = 1'b0, re = 1'b0;
  logic fu = 1'b0, em = 1'b1;
  logic [DW-1:0] wd = '0, rd0 = '0, rd1 = '0;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  fifo_scoreboard_if #(.DATA_W(DW)) i0 ();
  fifo_scoreboard_if #(.DATA_W(DW)) i1 ();

  assign i0.write_en   = we;
  assign i0.read_en    = re;
  assign i0.full       = fu;
  assign i0.empty      = em;
  assign i0.write_data = wd;
  assign i0.read_data  = rd0;
  assign i1.write_en   = we;
  assign i1.read_en    = re;
  assign i1.full       = fu;
  assign i1.empty      = em;
  assign i1.write_data = wd;
  assign i1.read_data  = rd1;

  logic [3:0]  cnt0, m0;
  logic        ed0, ef0, eo0, eu0, any0;
  logic [2:0]  cnt1;
  logic [15:0] m1;
  logic        ed1, ef1, eo1, eu1, any1;
`ifdef FIFO_SB_ERR_LOG_EN
  logic [DW-1:0] lx0, la0, lx1, la1;
  logic [3:0]    li0;
  logic [15:0]   li1;
`endif

  fifo_scoreboard #(
    .DATA_W(DW), .DEPTH(8), .RD_LAT(0), .CNT_W(4)
  ) u0 (
    .clk(clk), .rst(rst), .bus(i0),
    .model_count(cnt0), .match_cnt(m0),
    .err_data(ed0), .err_flag(ef0),
    .err_ovf(eo0), .err_udf(eu0), .err_any(any0)
`ifdef FIFO_SB_ERR_LOG_EN
    , .log_exp(lx0), .log_act(la0), .log_idx(li0)
`endif
  );

  fifo_scoreboard #(
    .DATA_W(DW), .DEPTH(5), .RD_LAT(1), .CNT_W(16)
  ) u1 (
    .clk(clk), .rst(rst), .bus(i1),
    .model_count(cnt1), .match_cnt(m1),
    .err_data(ed1), .err_flag(ef1),
    .err_ovf(eo1), .err_udf(eu1), .err_any(any1)
`ifdef FIFO_SB_ERR_LOG_EN
    , .log_exp(lx1), .log_act(la1), .log_idx(li1)
`endif
  );

  typedef struct {
    logic          we, re, fu, em;
    logic [DW-1:0] wd, rd;
    logic [3:0]    cnt, m, err;
  } vec_t;

  function automatic vec_t mk(
    input logic w, input logic r,
    input logic f, input logic e,
    input logic [DW-1:0] d, input logic [DW-1:0] q,
    input logic [3:0] c, input logic [3:0] m,
    input logic [3:0] er
  );
    vec_t v;
    v.we = w; v.re = r; v.fu = f; v.em = e;
    v.wd = d; v.rd = q;
    v.cnt = c; v.m = m; v.err = er;
    return v;
  endfunction

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; re = 1'b0; fu = 1'b0; em = 1'b1;
    wd = '0; rd0 = '0; rd1 = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  function automatic logic [12:0] st0();
    return {cnt0, m0, ed0, ef0, eo0, eu0, any0};
  endfunction

  function automatic logic [12:0] ex0(
    input logic [3:0] c, input logic [3:0] m,
    input logic [3:0] e
  );
    return {c, m, e, |e};
  endfunction

  vec_t tbl[9];

  // Randomized-run reference state
  logic [DW-1:0] q[$];
  int            mm;
  logic          xd, xf, xo, xu;

  task automatic rand_seg(input int n, input bit inj);
    logic wa, ra, cmp;
    logic [DW-1:0] ex;
    int sz;
    do_reset();
    q.delete();
    mm = 0;
    {xd, xf, xo, xu} = 4'b0;
    for (int c = 0; c < n; c++) begin
      we = 1'($urandom % 2);
      re = 1'($urandom % 2);
      wd = $urandom;
      sz = q.size();
      fu = (sz == 8);
      em = (sz == 0);
      if (inj && $urandom % 40 == 0) fu = !fu;
      if (inj && $urandom % 40 == 0) em = !em;
      rd0 = (sz > 0) ? q[0] : wd;
      if (inj && $urandom % 50 == 0)
        rd0 = rd0 ^ (32'd1 << ($urandom % 32));
      if (fu != (sz == 8) || em != (sz == 0)) xf = 1'b1;
      wa  = we && (!fu || re);
      ra  = re && (!em || we);
      cmp = 1'b0;
      ex  = '0;
      if (wa && ra) begin
        cmp = 1'b1;
        if (sz == 0) ex = wd;
        else begin
          ex = q.pop_front();
          q.push_back(wd);
        end
      end else if (wa) begin
        if (sz == 8) xo = 1'b1;
        else q.push_back(wd);
      end else if (ra) begin
        if (sz == 0) xu = 1'b1;
        else begin
          ex  = q.pop_front();
          cmp = 1'b1;
        end
      end
      if (cmp) begin
        if (rd0 != ex) xd = 1'b1;
        else if (mm < 15) mm++;
      end
      step();
      chk($sformatf("rand%0d", c), st0(),
          ex0(4'(q.size()), 4'(mm), {xd, xf, xo, xu}));
    end
  endtask

  initial begin
    tbl[0] = mk(1,0,0,1,32'h11,0, 4'd1,4'd0,4'b0000);
    tbl[1] = mk(1,0,0,0,32'h22,0, 4'd2,4'd0,4'b0000);
    tbl[2] = mk(1,0,0,0,32'h33,0, 4'd3,4'd0,4'b0000);
    tbl[3] = mk(0,1,0,0,0,32'h11, 4'd2,4'd1,4'b0000);
    tbl[4] = mk(0,1,0,0,0,32'h22, 4'd1,4'd2,4'b0000);
    tbl[5] = mk(0,1,0,0,0,32'h33, 4'd0,4'd3,4'b0000);
    tbl[6] = mk(1,1,0,1,32'hA5,32'hA5, 4'd0,4'd4,4'b0000);
    tbl[7] = mk(0,0,0,0,0,0, 4'd0,4'd4,4'b0100);
    tbl[8] = mk(0,1,0,0,0,0, 4'd0,4'd4,4'b0101);

    do_reset();
    chk("reset_u0", st0(), 13'd0);
    chk("reset_u1", {cnt1, m1, ed1, ef1, eo1, eu1, any1}, 0);

    for (int i = 0; i < 9; i++) begin
      we = tbl[i].we; re = tbl[i].re;
      fu = tbl[i].fu; em = tbl[i].em;
      wd = tbl[i].wd; rd0 = tbl[i].rd;
      step();
      chk($sformatf("tbl%0d", i), st0(),
          ex0(tbl[i].cnt, tbl[i].m, tbl[i].err));
    end

    // Wrong read data
    do_reset();
    we = 1; em = 1; wd = 32'hDEAD;
    step();
    chk("derr_pre", st0(), ex0(4'd1, 4'd0, 4'b0000));
    we = 0; re = 1; em = 0; rd0 = 32'hBEEF;
    step();
    chk("derr", st0(), ex0(4'd0, 4'd0, 4'b1000));
`ifdef FIFO_SB_ERR_LOG_EN
    chk("log_exp", lx0, 32'hDEAD);
    chk("log_act", la0, 32'hBEEF);
    chk("log_idx", li0, 4'd0);
`endif

    // Full with simultaneous read/write, then drain across the wrap
    do_reset();
    for (int i = 0; i < 8; i++) begin
      we = 1; re = 0; fu = 0; em = (i == 0);
      wd = i + 1;
      step();
    end
    chk("fill", st0(), ex0(4'd8, 4'd0, 4'b0000));
    for (int k = 0; k < 4; k++) begin
      we = 1; re = 1; fu = 1; em = 0;
      wd = 100 + k; rd0 = k + 1;
      step();
    end
    chk("full_rw", st0(), ex0(4'd8, 4'd4, 4'b0000));
    for (int k = 0; k < 8; k++) begin
      we = 0; re = 1; fu = (k == 0); em = 0;
      rd0 = (k < 4) ? 5 + k : 100 + k - 4;
      step();
    end
    chk("drain", st0(), ex0(4'd0, 4'd12, 4'b0000));
    for (int i = 0; i < 8; i++) begin
      we = 1; re = 0; fu = 0; em = (i == 0);
      wd = 200 + i;
      step();
    end
    we = 1; fu = 0; em = 0; wd = 32'h77;
    step();
    chk("ovf", st0(), ex0(4'd8, 4'd12, 4'b0110));
    rst = 1;
    step();
    chk("rst_mid", st0(), 13'd0);
    rst = 0;

    // Pipelined compare at read latency 1
    do_reset();
    for (int i = 0; i < 4; i++) begin
      we = 1; re = 0; fu = 0; em = (i == 0);
      wd = i + 1;
      step();
    end
    for (int j = 0; j < 4; j++) begin
      we = 0; re = 1; fu = 0; em = 0;
      rd1 = j;
      step();
      chk($sformatf("lat1_m%0d", j), m1, j);
    end
    re = 0; em = 1; rd1 = 4;
    step();
    chk("lat1_m4", m1, 16'd4);
    chk("lat1_st", {cnt1, ed1, ef1, eo1, eu1}, 0);
    we = 1; em = 1; wd = 7;
    step();
    we = 0; re = 1; em = 0; rd1 = 0;
    step();
    chk("lat1_pend", {ed1, m1}, {1'b0, 16'd4});
    re = 0; em = 1; rd1 = 8;
    step();
    chk("lat1_derr", {ed1, m1}, {1'b1, 16'd4});

    rand_seg(300, 1'b0);
    rand_seg(300, 1'b0);
    rand_seg(300, 1'b1);
    rand_seg(300, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fifo_scoreboard.md
# fifo_scoreboard

Synthesizable, parametrised in-order reference model and checker for the team's synchronous FIFOs. It mirrors every accepted write into a shadow queue and compares every accepted read against the queue head. It also cross-checks the DUT's `full`/`empty` flags against its own occupancy. It is instantiated beside (or bound to) the FIFO top level and produces sticky error flags and counters for formal assertions and simulation alike.

## Interface
Parameters:
- `DATA_W`, 32, width of write/read data.
- `DEPTH`, 8, FIFO capacity in entries; ≥2, any value (not restricted to powers of two).
- `RD_LAT`, 0, read-data latency of the DUT: 0 = `read_data` is valid in the accept cycle; 1 = valid one cycle after.
- `CNT_W`, 16, width of the saturating match counter.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `write_en`  in  1  DUT write request.
- `read_en`  in  1  DUT read request.
- `full`  in  1  DUT full flag.
- `empty`  in  1  DUT empty flag.
- `write_data`  in  DATA_W  DUT write data.
- `read_data`  in  DATA_W  DUT read data.
- `model_count`  out  $clog2(DEPTH+1)  shadow-queue occupancy.
- `match_cnt`  out  CNT_W  number of correct reads, saturating.
- `err_data`  out  1  sticky; a read returned wrong data.
- `err_flag`  out  1  sticky; `full`/`empty` disagreed with the model.
- `err_ovf`  out  1  sticky; write accepted while the model was full.
- `err_udf`  out  1  sticky; read accepted while the model was empty.
- `err_any`  out  1  OR of all four error flags (combinational from registers).

## Operation
- Acceptance is decoded internally:
  - `wr_acc = write_en && (!full || read_en)`
  - `rd_acc = read_en && (!empty || write_en)`
- Shadow queue: DEPTH×DATA_W circular buffer with read/write pointers. Pointers wrap from DEPTH-1 to 0.
- Expected-data selection on `rd_acc`:
  - Model count > 0: expected = head entry.
  - Model count == 0 and `wr_acc` in the same cycle: bypass, expected = `write_data`. Nothing is stored and the count is unchanged.
- Count update:
  - `wr_acc` only: +1.
  - `rd_acc` only: −1.
  - Both: unchanged, with both the push and the pop performed (or bypass, as above).
- Overflow: `wr_acc && !rd_acc && count==DEPTH` → set `err_ovf`, drop the write, leave the count unchanged.
- Underflow: `rd_acc && !wr_acc && count==0` → set `err_udf`, no compare, count stays 0.
- Flag check, every cycle outside reset: `full != (count==DEPTH)` or `empty != (count==0)` → set `err_flag`.
- Compare: `read_data != expected` → set `err_data`; otherwise increment `match_cnt` (holds at 2^CNT_W−1).
- Error flags are sticky until `rst`.

## Timing
- Reset values: `model_count`=0, `match_cnt`=0, all `err_*`=0, pointers=0. Queue contents are don't-care.
- Reset may assert at any cycle. Asserting it mid-traffic clears all state on the same edge; checking resumes on the first rising edge after deassertion.
- RD_LAT=0: the compare uses `read_data` in the accept cycle. `err_data`/`match_cnt` update at the following edge (visible 1 cycle after accept).
- RD_LAT=1: expected data and a pending bit are registered at the accept edge. The compare uses `read_data` in the next cycle, so results are visible 2 cycles after accept. Back-to-back reads are pipelined, one compare per cycle.
- `err_flag`, `err_ovf`, `err_udf` and `model_count` are visible 1 cycle after the causing cycle.

## Configuration
- `FIFO_SB_ERR_LOG_EN` defined:
  - Adds outputs `log_exp` (DATA_W), `log_act` (DATA_W) and `log_idx` (CNT_W).
  - On the first `err_data` they capture the expected value, the actual value and the `match_cnt` at that moment, then freeze until reset. Reset value is 0.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

## Test plan
- Write 0x11,0x22,0x33 then read 3 (RD_LAT=0, DEPTH=8) → `match_cnt`=3, `model_count`=0, `err_any`=0.
- Fill 8 entries, DUT drives `full`=1; hold `write_en` with `read_en`=1 for 4 cycles → count stays 8, 4 matches, no `err_ovf`.
- Empty FIFO, `write_en`=`read_en`=1 with `write_data`=`read_data`=0xA5 → bypass match, `match_cnt`=1, count=0.
- Write 0xDEAD, DUT returns 0xBEEF on read → `err_data`=1 one cycle later. With `FIFO_SB_ERR_LOG_EN`: `log_exp`=0xDEAD, `log_act`=0xBEEF, `log_idx`=0.
- Force `empty`=0 while count=0 → `err_flag`=1 next cycle; `rst` pulse mid-sequence → all outputs 0 on the next edge.
- RD_LAT=1, 4 back-to-back reads of 1,2,3,4 → `match_cnt` steps 1..4 starting 2 cycles after the first accept.
